// File: rtl/cond_unit.sv
// Condition-check stage: latches ALU NZCV flags and gates the write-enable and
// branch strobes of the instruction entering execute by its condition field.
module cond_unit #(
    parameter bit         BYPASS    = 1'b1,
    parameter logic [3:0] RST_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stall_i,
    input  logic       flush_i,
    input  logic [3:0] banderas_i,
    input  logic       flag_we_i,
    input  logic       valid_i,
    input  logic [3:0] cond_i,
    input  logic       reg_we_i,
    input  logic       mem_we_i,
    input  logic       branch_i,
    output logic       valid_o,
    output logic       cond_ok_o,
    output logic       reg_we_o,
    output logic       mem_we_o,
    output logic       pc_src_o,
    output logic [3:0] flags_o
);

    // Handshake: valid_i qualifies the instruction fields in the same cycle;
    // there is no ready, the upstream holds via stall_i and kills via flush_i.

    logic [3:0] flags_q, flags_d;
    logic [3:0] eff_flags;
    logic       ok;
    logic       flag_n, flag_z, flag_c, flag_v;

    logic valid_q, valid_d;
    logic cond_ok_q, cond_ok_d;
    logic reg_we_q, reg_we_d;
    logic mem_we_q, mem_we_d;
    logic pc_src_q, pc_src_d;

    // The forwarded value is used even while stalled; only capture is frozen.
    assign eff_flags = (BYPASS && flag_we_i) ? banderas_i : flags_q;
    assign flag_n    = eff_flags[3];
    assign flag_z    = eff_flags[2];
    assign flag_c    = eff_flags[1];
    assign flag_v    = eff_flags[0];

    always_comb begin
        ok = 1'b0;
        case (cond_i)
            4'b0000: ok = flag_z;
            4'b0001: ok = !flag_z;
            4'b0010: ok = flag_c;
            4'b0011: ok = !flag_c;
            4'b0100: ok = flag_n;
            4'b0101: ok = !flag_n;
            4'b0110: ok = flag_v;
            4'b0111: ok = !flag_v;
            4'b1000: ok = flag_c && !flag_z;
            4'b1001: ok = !flag_c || flag_z;
            4'b1010: ok = (flag_n == flag_v);
            4'b1011: ok = (flag_n != flag_v);
            4'b1100: ok = !flag_z && (flag_n == flag_v);
            4'b1101: ok = flag_z || (flag_n != flag_v);
            4'b1110: ok = 1'b1;
            4'b1111: ok = 1'b0;
            default: ok = 1'b0;
        endcase
    end

    // Flush does not block the flag write: the producer is older than the
    // instruction being killed.
    always_comb begin
        flags_d = flags_q;
        if (flag_we_i && !stall_i) begin
            flags_d = banderas_i;
        end
    end

    always_comb begin
        valid_d   = valid_q;
        cond_ok_d = cond_ok_q;
        reg_we_d  = reg_we_q;
        mem_we_d  = mem_we_q;
        pc_src_d  = pc_src_q;
        if (flush_i) begin
            valid_d   = 1'b0;
            cond_ok_d = 1'b0;
            reg_we_d  = 1'b0;
            mem_we_d  = 1'b0;
            pc_src_d  = 1'b0;
        end else if (!stall_i) begin
            valid_d   = valid_i;
            cond_ok_d = valid_i && ok;
            reg_we_d  = valid_i && ok && reg_we_i;
            mem_we_d  = valid_i && ok && mem_we_i;
            pc_src_d  = valid_i && ok && branch_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q   <= RST_FLAGS;
            valid_q   <= 1'b0;
            cond_ok_q <= 1'b0;
            reg_we_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            pc_src_q  <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            valid_q   <= valid_d;
            cond_ok_q <= cond_ok_d;
            reg_we_q  <= reg_we_d;
            mem_we_q  <= mem_we_d;
            pc_src_q  <= pc_src_d;
        end
    end

    assign valid_o   = valid_q;
    assign cond_ok_o = cond_ok_q;
    assign reg_we_o  = reg_we_q;
    assign mem_we_o  = mem_we_q;
    assign pc_src_o  = pc_src_q;
    assign flags_o   = flags_q;

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: hand-derived vector table through a one-deep expected
// queue, plus sequences for the no-bypass variant and asynchronous reset.
module tb_cond_unit;

  logic       clk;
  logic       rst_n;
  logic       stall_i, flush_i, flag_we_i, valid_i, reg_we_i, mem_we_i, branch_i;
  logic [3:0] banderas_i, cond_i;

  logic       valid_o, cond_ok_o, reg_we_o, mem_we_o, pc_src_o;
  logic [3:0] flags_o;
  logic       nb_valid_o, nb_cond_ok_o, nb_reg_we_o, nb_mem_we_o, nb_pc_src_o;
  logic [3:0] nb_flags_o;

  int n_vec;
  int n_err;

  // expected record: {valid, cond_ok, reg_we, mem_we, pc_src, flags[3:0]}
  logic [8:0] exp_q[$];

  typedef struct {
    logic       st;
    logic       fl;
    logic [3:0] band;
    logic       fwe;
    logic       v;
    logic [3:0] cond;
    logic       rwe;
    logic       mwe;
    logic       br;
    logic [8:0] exp;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vt[NVEC];

  cond_unit #(.BYPASS(1'b1), .RST_FLAGS(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .banderas_i(banderas_i), .flag_we_i(flag_we_i), .valid_i(valid_i),
    .cond_i(cond_i), .reg_we_i(reg_we_i), .mem_we_i(mem_we_i), .branch_i(branch_i),
    .valid_o(valid_o), .cond_ok_o(cond_ok_o), .reg_we_o(reg_we_o),
    .mem_we_o(mem_we_o), .pc_src_o(pc_src_o), .flags_o(flags_o)
  );

  cond_unit #(.BYPASS(1'b0), .RST_FLAGS(4'b0000)) dut_nb (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .banderas_i(banderas_i), .flag_we_i(flag_we_i), .valid_i(valid_i),
    .cond_i(cond_i), .reg_we_i(reg_we_i), .mem_we_i(mem_we_i), .branch_i(branch_i),
    .valid_o(nb_valid_o), .cond_ok_o(nb_cond_ok_o), .reg_we_o(nb_reg_we_o),
    .mem_we_o(nb_mem_we_o), .pc_src_o(nb_pc_src_o), .flags_o(nb_flags_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, input logic fl, input logic [3:0] band,
                              input logic fwe, input logic v, input logic [3:0] cond,
                              input logic rwe, input logic mwe, input logic br,
                              input logic [8:0] exp);
    vec_t r;
    r.st = st; r.fl = fl; r.band = band; r.fwe = fwe; r.v = v; r.cond = cond;
    r.rwe = rwe; r.mwe = mwe; r.br = br; r.exp = exp;
    return r;
  endfunction

  function automatic logic [8:0] dut_out();
    return {valid_o, cond_ok_o, reg_we_o, mem_we_o, pc_src_o, flags_o};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // driver
  task automatic drive(input vec_t v);
    stall_i    = v.st;
    flush_i    = v.fl;
    banderas_i = v.band;
    flag_we_i  = v.fwe;
    valid_i    = v.v;
    cond_i     = v.cond;
    reg_we_i   = v.rwe;
    mem_we_i   = v.mwe;
    branch_i   = v.br;
  endtask

  initial begin
    logic [8:0] e;
    n_vec = 0;
    n_err = 0;

    //                st  fl  band     fwe v   cond     rwe mwe br   exp {v,ok,r,m,pc,NZCV}
    vt[0]  = mk(1'b0,1'b0,4'b0000,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0, 9'b0_0_0_0_0_0000);
    vt[1]  = mk(1'b0,1'b0,4'b0000,1'b0,1'b0,4'b1110,1'b1,1'b1,1'b1, 9'b0_0_0_0_0_0000);
    vt[2]  = mk(1'b0,1'b0,4'b0100,1'b1,1'b1,4'b0000,1'b0,1'b0,1'b1, 9'b1_1_0_0_1_0100);
    vt[3]  = mk(1'b0,1'b0,4'b1000,1'b1,1'b1,4'b1110,1'b1,1'b0,1'b0, 9'b1_1_1_0_0_1000);
    vt[4]  = mk(1'b0,1'b0,4'b0000,1'b0,1'b1,4'b1010,1'b1,1'b0,1'b0, 9'b1_0_0_0_0_1000);
    vt[5]  = mk(1'b0,1'b0,4'b0000,1'b0,1'b1,4'b1011,1'b1,1'b0,1'b0, 9'b1_1_1_0_0_1000);
    vt[6]  = mk(1'b0,1'b0,4'b0000,1'b0,1'b1,4'b1100,1'b1,1'b0,1'b0, 9'b1_0_0_0_0_1000);
    vt[7]  = mk(1'b0,1'b0,4'b0000,1'b0,1'b1,4'b1101,1'b1,1'b0,1'b0, 9'b1_1_1_0_0_1000);
    vt[8]  = mk(1'b0,1'b0,4'b0010,1'b1,1'b1,4'b1000,1'b0,1'b1,1'b0, 9'b1_1_0_1_0_0010);
    vt[9]  = mk(1'b0,1'b0,4'b0000,1'b0,1'b1,4'b1001,1'b0,1'b1,1'b0, 9'b1_0_0_0_0_0010);
    vt[10] = mk(1'b0,1'b0,4'b0110,1'b1,1'b1,4'b1000,1'b0,1'b1,1'b0, 9'b1_0_0_0_0_0110);
    vt[11] = mk(1'b0,1'b0,4'b0000,1'b0,1'b1,4'b1001,1'b0,1'b1,1'b0, 9'b1_1_0_1_0_0110);
    vt[12] = mk(1'b0,1'b0,4'b0100,1'b1,1'b1,4'b1111,1'b1,1'b1,1'b1, 9'b1_0_0_0_0_0100);
    vt[13] = mk(1'b0,1'b0,4'b0000,1'b0,1'b1,4'b1110,1'b1,1'b1,1'b1, 9'b1_1_1_1_1_0100);
    vt[14] = mk(1'b1,1'b0,4'b0001,1'b1,1'b1,4'b1111,1'b0,1'b0,1'b0, 9'b1_1_1_1_1_0100);
    vt[15] = mk(1'b1,1'b0,4'b0001,1'b1,1'b1,4'b1111,1'b0,1'b0,1'b0, 9'b1_1_1_1_1_0100);
    vt[16] = mk(1'b1,1'b0,4'b0001,1'b1,1'b1,4'b1111,1'b0,1'b0,1'b0, 9'b1_1_1_1_1_0100);
    vt[17] = mk(1'b1,1'b1,4'b0001,1'b1,1'b1,4'b1110,1'b1,1'b1,1'b1, 9'b0_0_0_0_0_0100);
    vt[18] = mk(1'b0,1'b0,4'b0001,1'b1,1'b1,4'b0110,1'b0,1'b0,1'b1, 9'b1_1_0_0_1_0001);
    vt[19] = mk(1'b0,1'b1,4'b1000,1'b1,1'b1,4'b1110,1'b1,1'b1,1'b1, 9'b0_0_0_0_0_1000);
    vt[20] = mk(1'b0,1'b0,4'b0000,1'b0,1'b0,4'b0111,1'b1,1'b1,1'b1, 9'b0_0_0_0_0_1000);
    vt[21] = mk(1'b0,1'b0,4'b0100,1'b1,1'b1,4'b0000,1'b0,1'b0,1'b1, 9'b1_1_0_0_1_0100);

    // reset with a flag write pending: it must be ignored
    rst_n = 1'b0;
    drive(mk(1'b0,1'b0,4'b1111,1'b1,1'b1,4'b1110,1'b1,1'b1,1'b1, 9'b0));
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", dut_out(), 9'b0_0_0_0_0_0000);
    check("reset_state_nb", {nb_valid_o, nb_cond_ok_o, nb_reg_we_o, nb_mem_we_o,
                             nb_pc_src_o, nb_flags_o}, 9'b0_0_0_0_0_0000);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      vec_t v;
      v = vt[i];
      // with valid_i low and no stall the condition field is irrelevant
      if (!v.v && !v.st) v.cond = 4'($urandom_range(0, 15));
      drive(v);
      exp_q.push_back(v.exp);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL vec%0d: expected queue empty", i);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("vec%0d", i), dut_out(), e);
      end
      // registered flags only, so the no-bypass branch is not taken
      if (i == 2) begin
        check("nobypass_eq_branch",
              {4'b0, nb_pc_src_o, nb_flags_o}, {4'b0, 1'b0, 4'b0100});
      end
    end

    // asynchronous reset between edges while a branch is being signalled
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_pc_flags", {4'b0, pc_src_o, flags_o}, 9'b0);
    check("async_reset_all", dut_out(), 9'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(1'b0,1'b0,4'b0000,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0, 9'b0));
    @(posedge clk);
    #1;
    check("post_reset_idle", dut_out(), 9'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
